ic74hc151_mux: RTL and testbench



---
 rtl/ic74hc151_pkg.sv | 15 +
 rtl/ic74hc151_core.sv | 30 +++
 rtl/ic74hc151_mux.sv | 76 +++++++
 tb/tb_ic74hc151_mux.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ic74hc151_pkg.sv
// Shared widths, reset constants and select validation for the 74HC151-style mux.
package ic74hc151_pkg;

  localparam int   SEL_W_DEF  = 3;
  localparam int   DATA_W_DEF = 8;
  localparam logic Y_RST      = 1'b0;
  localparam logic YF_RST     = 1'b1;

  // A select is usable only when fully known and addressing an existing input.
  function automatic logic sel_valid(input logic [31:0] sel, input int n);
    if ($isunknown(sel)) return 1'b0;
    return (sel < 32'(n));
  endfunction

endpackage

// File: rtl/ic74hc151_core.sv
// Purely combinational 2^N-to-1 selector with active-low enable; unknown or
// out-of-range select and unknown/high enable all force a 0 output.
import ic74hc151_pkg::*;

module ic74hc151_core #(
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_en_n,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_y
);

  logic [DATA_W-1:0] w_hit;
  logic              w_enabled;
  logic              w_valid;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_hit
      assign w_hit[gi] = (32'(i_sel) == 32'(gi)) & i_data[gi];
    end
  endgenerate

  // Case equality keeps an unknown enable from leaking X into the output.
  assign w_enabled = (i_en_n === 1'b0);
  assign w_valid   = sel_valid(32'(i_sel), DATA_W);
  assign o_y       = w_enabled & w_valid & (|w_hit);

endmodule

// File: rtl/ic74hc151_mux.sv
// Registered 74HC151 equivalent: core mux plus a single output register (Y/YF).
// Optional input registering is selected with macro IC74HC151_IN_REG_EN.
import ic74hc151_pkg::*;

module ic74hc151_mux #(
  parameter int DATA_SelectPart  = SEL_W_DEF,
  parameter int DATA_Single_Part = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        EN_Part,
  input  logic [DATA_SelectPart-1:0]  SelectPart,
  input  logic [DATA_Single_Part-1:0] Single_Part,
  output logic                        Y,
  output logic                        YF
);

  generate
    if (DATA_Single_Part < 1 || DATA_Single_Part > (2 ** DATA_SelectPart)) begin : g_param_err
      $error("ic74hc151_mux: DATA_Single_Part must be in 1..2**DATA_SelectPart");
    end
  endgenerate

  logic                        w_en_n;
  logic [DATA_SelectPart-1:0]  w_sel;
  logic [DATA_Single_Part-1:0] w_data;
  logic                        w_y;
  logic                        r_y;

`ifdef IC74HC151_IN_REG_EN
  logic                        r_en_n;
  logic [DATA_SelectPart-1:0]  r_sel;
  logic [DATA_Single_Part-1:0] r_data;

  // Input stage resets to "disabled" so the mux output stays 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_n <= 1'b1;
      r_sel  <= '0;
      r_data <= '0;
    end else begin
      r_en_n <= EN_Part;
      r_sel  <= SelectPart;
      r_data <= Single_Part;
    end
  end

  assign w_en_n = r_en_n;
  assign w_sel  = r_sel;
  assign w_data = r_data;
`else
  assign w_en_n = EN_Part;
  assign w_sel  = SelectPart;
  assign w_data = Single_Part;
`endif

  ic74hc151_core #(
    .SEL_W  (DATA_SelectPart),
    .DATA_W (DATA_Single_Part)
  ) u_core (
    .i_en_n (w_en_n),
    .i_sel  (w_sel),
    .i_data (w_data),
    .o_y    (w_y)
  );

  always_ff @(posedge clk) begin
    if (rst) r_y <= Y_RST;
    else     r_y <= w_y;
  end

  // Both outputs derive from r_y, so YF is the complement even during reset.
  assign Y  = r_y;
  assign YF = ~r_y;

endmodule

// File: tb/tb_ic74hc151_mux.sv
// Directed self-checking bench for ic74hc151_mux (8-input and 5-input instances).
`timescale 1ns/1ps
module tb_ic74hc151_mux;

`ifdef IC74HC151_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] sel;
  logic [7:0] data;
  logic       y, yf;
  logic [2:0] sel5;
  logic [4:0] data5;
  logic       y5, yf5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ic74hc151_mux #(.DATA_SelectPart(3), .DATA_Single_Part(8)) dut (
    .clk(clk), .rst(rst), .EN_Part(en), .SelectPart(sel), .Single_Part(data),
    .Y(y), .YF(yf)
  );

  ic74hc151_mux #(.DATA_SelectPart(3), .DATA_Single_Part(5)) dut5 (
    .clk(clk), .rst(rst), .EN_Part(en), .SelectPart(sel5), .Single_Part(data5),
    .Y(y5), .YF(yf5)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sel = 3'd2; data = 8'hFF; sel5 = 3'd1; data5 = 5'h1F;
    for (int c = 0; c < 2; c++) begin
      tick(1);
      checks++;
      if (y !== 1'b0 || yf !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: Y=%b YF=%b, expected Y=0 YF=1", c, y, yf);
      end else $display("reset_hold cycle %0d: Y=%b YF=%b", c, y, yf);
    end
    rst = 1'b0; en = 1'b1;
    tick(LAT + 1);
    checks++;
    if (y !== 1'b0 || yf !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_disabled: Y=%b YF=%b, expected Y=0 YF=1", y, yf);
    end else $display("reset_release_disabled: Y=%b YF=%b", y, yf);
  endtask

  task automatic test_sweep();
    logic [7:0] exp_bits;
    int idx;
    exp_bits = 8'b1011_1101;
    data = 8'b1011_1101; en = 1'b0;
    for (int k = 0; k < 8 + LAT - 1; k++) begin
      if (k < 8) sel = 3'(k);
      tick(1);
      idx = k + 1 - LAT;
      if (idx >= 0) begin
        checks++;
        if (y !== exp_bits[idx] || yf !== ~exp_bits[idx]) begin
          errors++;
          $display("FAIL sweep sel=%0d: Y=%b YF=%b, expected Y=%b YF=%b",
                   idx, y, yf, exp_bits[idx], ~exp_bits[idx]);
        end else $display("sweep sel=%0d: Y=%b YF=%b", idx, y, yf);
      end
    end
  endtask

  task automatic test_disable();
    logic [2:0] en_seq;
    logic [2:0] exp_y;
    en_seq = 3'b010;   // en applied as 0,1,0 (bit 0 first)
    exp_y  = 3'b101;
    sel = 3'd0; data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      en = en_seq[k];
      tick(LAT);
      checks++;
      if (y !== exp_y[k] || yf !== ~exp_y[k]) begin
        errors++;
        $display("FAIL disable en=%b: Y=%b YF=%b, expected Y=%b YF=%b",
                 en, y, yf, exp_y[k], ~exp_y[k]);
      end else $display("disable en=%b: Y=%b YF=%b", en, y, yf);
    end
  endtask

  task automatic test_wrap_range();
    en = 1'b0; data = 8'h01;
    sel = 3'd7;
    tick(LAT);
    checks++;
    if (y !== 1'b0 || yf !== 1'b1) begin
      errors++;
      $display("FAIL wrap sel=7: Y=%b YF=%b, expected Y=0 YF=1", y, yf);
    end else $display("wrap sel=7: Y=%b YF=%b", y, yf);
    sel = 3'd0;
    tick(LAT);
    checks++;
    if (y !== 1'b1 || yf !== 1'b0) begin
      errors++;
      $display("FAIL wrap sel=0: Y=%b YF=%b, expected Y=1 YF=0", y, yf);
    end else $display("wrap sel=0: Y=%b YF=%b", y, yf);

    data5 = 5'b11111;
    sel5 = 3'd4;
    tick(LAT);
    checks++;
    if (y5 !== 1'b1 || yf5 !== 1'b0) begin
      errors++;
      $display("FAIL range5 sel=4: Y=%b YF=%b, expected Y=1 YF=0", y5, yf5);
    end else $display("range5 sel=4: Y=%b YF=%b", y5, yf5);
    sel5 = 3'd5;
    tick(LAT);
    checks++;
    if (y5 !== 1'b0 || yf5 !== 1'b1) begin
      errors++;
      $display("FAIL range5 sel=5: Y=%b YF=%b, expected Y=0 YF=1", y5, yf5);
    end else $display("range5 sel=5: Y=%b YF=%b", y5, yf5);
    sel5 = 3'd6;
    tick(LAT);
    checks++;
    if (y5 !== 1'b0 || yf5 !== 1'b1) begin
      errors++;
      $display("FAIL range5 sel=6: Y=%b YF=%b, expected Y=0 YF=1", y5, yf5);
    end else $display("range5 sel=6: Y=%b YF=%b", y5, yf5);

    data = 8'h00; sel = 3'bxxx;
    tick(LAT);
    checks++;
    if (y !== 1'b0 || yf !== 1'b1) begin
      errors++;
      $display("FAIL sel_unknown: Y=%b YF=%b, expected Y=0 YF=1", y, yf);
    end else $display("sel_unknown: Y=%b YF=%b", y, yf);
    sel = 3'd0;
  endtask

  task automatic test_reset_midstream();
    en = 1'b0; data = 8'b1011_1101;
    sel = 3'd0;
    tick(LAT);
    checks++;
    if (y !== 1'b1 || yf !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre: Y=%b YF=%b, expected Y=1 YF=0", y, yf);
    end else $display("midreset_pre: Y=%b YF=%b", y, yf);
    rst = 1'b1; sel = 3'd2;
    tick(1);
    checks++;
    if (y !== 1'b0 || yf !== 1'b1) begin
      errors++;
      $display("FAIL midreset_edge: Y=%b YF=%b, expected Y=0 YF=1", y, yf);
    end else $display("midreset_edge: Y=%b YF=%b", y, yf);
    rst = 1'b0; sel = 3'd3;
    tick(1);
    sel = 3'd6;
    tick(LAT - 1);
    checks++;
    if (y !== 1'b1 || yf !== 1'b0) begin
      errors++;
      $display("FAIL midreset_resume sel=3: Y=%b YF=%b, expected Y=1 YF=0", y, yf);
    end else $display("midreset_resume sel=3: Y=%b YF=%b", y, yf);
    tick(1);
    checks++;
    if (y !== 1'b0 || yf !== 1'b1) begin
      errors++;
      $display("FAIL midreset_resume sel=6: Y=%b YF=%b, expected Y=0 YF=1", y, yf);
    end else $display("midreset_resume sel=6: Y=%b YF=%b", y, yf);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sel = '0; data = '0; sel5 = '0; data5 = '0;
    #2;
    test_reset();
    test_sweep();
    test_disable();
    test_wrap_range();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
